// File: rtl/alu_sequencer.sv
// alu_sequencer: register file plus a 3-cycle IDLE/EXEC/DONE sequencer that
// feeds registered operands to an external combinational ALU and writes the
// result back to the destination register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for an instruction; side load port active
//   EXEC  | latched operands presented to the ALU; writeback at exit edge
//   DONE  | done pulse for the retired instruction; returns to IDLE
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [W-1:0]             ld_data,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [3:0]               alu_op,
  input  logic [W-1:0]             alu_result,
  output logic                     done,
  output logic                     illegal,
  output logic [W-1:0]             wb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [W-1:0]             dbg_data
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [W-1:0]  regs [NREGS];
  logic [AW-1:0] rd_q;
  logic          illegal_q;
  logic          accept;

  logic [3:0]    f_op;
  logic [AW-1:0] f_rd, f_rs1, f_rs2;
  logic          unused_reserved;

  assign f_op  = instr[3:0];
  assign f_rd  = instr[6:4];
  assign f_rs1 = instr[9:7];
  assign f_rs2 = instr[12:10];
  // Reserved bits are deliberately ignored.
  assign unused_reserved = ^instr[15:13];

  assign accept = instr_valid & instr_ready;

  // R0 is hardwired to zero on every read path.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = S_EXEC;
      end
      S_EXEC: next_state = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        illegal    = illegal_q;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand/opcode capture on accept; reads use pre-edge register contents,
  // so a same-cycle load is not seen by the accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      alu_a     <= (f_rs1 == '0) ? '0 : regs[f_rs1];
      alu_b     <= (f_rs2 == '0) ? '0 : regs[f_rs2];
      alu_op    <= f_op;
      rd_q      <= f_rd;
      illegal_q <= (f_op > 4'd4);
    end
  end

  // Capture of the ALU result at the end of EXEC, including discarded ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wb_data <= '0;
    else if (state == S_EXEC)  wb_data <= alu_result;
  end

  // Register file: side loads only in IDLE, writeback only leaving EXEC.
  // The two never coincide since they are gated by different states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == S_IDLE && ld_en && ld_addr != '0) begin
      regs[ld_addr] <= ld_data;
    end else if (state == S_EXEC && !illegal_q && rd_q != '0) begin
      regs[rd_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed plan items plus random
// instruction streams checked against a behavioural register-file model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_result;
  logic        done, illegal;
  logic [7:0]  wb_data;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done;
  bit gap_chk  = 1'b0;

  logic [7:0] model [8];

  alu_sequencer #(.NREGS(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .done(done), .illegal(illegal),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: 0 add, 1 sub, 2 and, 3 or, 4 slt (unsigned), else xor.
  function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                        input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      4'd0: return 8'((sa + sb) % 256);
      4'd1: return 8'((sa - sb + 256) % 256);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return (sa < sb) ? 8'd1 : 8'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic dbg_check(input logic [2:0] a);
    dbg_addr = a; #1;
    check($sformatf("dbg_r%0d", a), dbg_data, model[a]);
  endtask

  task automatic dbg_expect(input logic [2:0] a, input logic [7:0] v);
    dbg_addr = a; #1;
    check($sformatf("dbg_r%0d_const", a), dbg_data, v);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    step();
    ld_en = 1'b0;
    if (a != 0) model[a] = v;
  endtask

  // Runs one instruction from an IDLE cycle through to the next IDLE cycle.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input bit hold, input bit ld_acc, input bit ld_exe,
                       input logic [2:0] la, input logic [7:0] lv);
    logic [7:0] ea, eb, er;
    ea = (rs1 == 0) ? 8'h00 : model[rs1];
    eb = (rs2 == 0) ? 8'h00 : model[rs2];
    er = alu_fn(op, ea, eb);
    check("ready_idle", instr_ready, 1);
    instr = {3'($urandom_range(0, 7)), rs2, rs1, rd, op};
    instr_valid = 1'b1;
    if (ld_acc) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    step();
    ld_en = 1'b0;
    if (ld_acc && la != 0) model[la] = lv;
    instr = 16'($urandom);
    if (!hold) instr_valid = 1'b0;
    check("ready_exec", instr_ready, 0);
    check("done_exec", done, 0);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_op", alu_op, op);
    if (ld_exe) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    step();
    ld_en = 1'b0;
    check("ready_done", instr_ready, 0);
    check("done", done, 1);
    check("illegal", illegal, (op > 4) ? 1 : 0);
    check("wb_data", wb_data, er);
    if (gap_chk && last_done >= 0) check("done_gap", cyc - last_done, 3);
    last_done = cyc;
    if (op <= 4 && rd != 0) model[rd] = er;
    step();
    instr_valid = 1'b0;
    check("done_low", done, 0);
    check("illegal_low", illegal, 0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0; last_done = -1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    // Reset values
    #3;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_wb", wb_data, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_ready", instr_ready, 1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    step();

    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    dbg_expect(3'd1, 8'h05);
    dbg_expect(3'd2, 8'h03);

    // Arithmetic with wrap and zero-extend
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    dbg_expect(3'd3, 8'h08);
    do_load(3'd1, 8'hFF);
    do_load(3'd2, 8'h02);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    dbg_expect(3'd3, 8'h01);
    issue(4'd1, 3'd4, 3'd2, 3'd1, 0, 0, 0, 0, 0);
    dbg_expect(3'd4, 8'h03);
    issue(4'd4, 3'd5, 3'd2, 3'd1, 0, 0, 0, 0, 0);
    dbg_expect(3'd5, 8'h01);

    // Logic ops back-to-back with valid held high
    do_load(3'd1, 8'hF0);
    do_load(3'd2, 8'h3C);
    gap_chk = 1'b1; last_done = -1;
    issue(4'd2, 3'd3, 3'd1, 3'd2, 1, 0, 0, 0, 0);
    issue(4'd3, 3'd4, 3'd1, 3'd2, 1, 0, 0, 0, 0);
    issue(4'd2, 3'd5, 3'd4, 3'd3, 0, 0, 0, 0, 0);
    gap_chk = 1'b0;
    dbg_expect(3'd3, 8'h30);
    dbg_expect(3'd4, 8'hFC);

    // R0 and illegal
    issue(4'd0, 3'd0, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    dbg_expect(3'd0, 8'h00);
    issue(4'd7, 3'd4, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    dbg_expect(3'd4, 8'hFC);
    do_load(3'd0, 8'hAA);
    dbg_expect(3'd0, 8'h00);

    // Hazard, load during EXEC, load colliding with accept
    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1, 0, 0, 0, 0);
    issue(4'd0, 3'd4, 3'd3, 3'd1, 0, 0, 0, 0, 0);
    dbg_expect(3'd4, 8'h0D);
    issue(4'd3, 3'd6, 3'd1, 3'd2, 0, 0, 1, 3'd2, 8'h77);
    dbg_expect(3'd2, 8'h03);
    issue(4'd0, 3'd5, 3'd1, 3'd0, 0, 1, 0, 3'd1, 8'h10);
    dbg_expect(3'd5, 8'h05);
    dbg_expect(3'd1, 8'h10);

    // Random stream against the model
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
      if ($urandom_range(0, 3) == 0)
        do_load(3'($urandom), 8'($urandom));
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) dbg_check(3'(i));

    // Reset during EXEC abandons the instruction
    do_load(3'd1, 8'h21);
    do_load(3'd2, 8'h12);
    instr = {3'b000, 3'd2, 3'd1, 3'd6, 4'd0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("mid_exec_ready", instr_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", instr_ready, 1);
    check("mid_rst_alu_a", alu_a, 0);
    dbg_expect(3'd6, 8'h00);
    for (int j = 0; j < 3; j++) begin
      step();
      check("mid_rst_hold_done", done, 0);
      check("mid_rst_hold_ready", instr_ready, 1);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    check("post_rst_done", done, 0);
    dbg_check(3'd6);
    dbg_check(3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
